// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one falling-edge datapath register between R requesters.
// Define REG_ARB_LOCK_EN to enable bounded ownership locking (LOCK state, lock_cnt, locked).
module reg_write_arbiter #(
    parameter int unsigned N        = 32,
    parameter int unsigned R        = 4,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [R-1:0]         req,
    input  logic [R-1:0]         lock,
    input  logic [R*N-1:0]       wdata,
    output logic [R-1:0]         gnt,
    output logic [N-1:0]         q,
    output logic                 q_valid,
    output logic [$clog2(R)-1:0] owner,
    output logic                 locked
);

    localparam int unsigned IdxW = $clog2(R);

    if (R < 2 || R > 8) begin : gen_bad_r
        $error("reg_write_arbiter: R must be in 2..8");
    end
    if (LOCK_MAX < 1 || LOCK_MAX > 255) begin : gen_bad_lock_max
        $error("reg_write_arbiter: LOCK_MAX must be in 1..255");
    end

    typedef enum logic [1:0] {
        StIdle,
        StServe,
        StLock
    } state_e;

    state_e          state;
    logic [IdxW-1:0] ptr;
    logic [N-1:0]    wdata_arr [R];
    logic [IdxW-1:0] cand;
    logic [IdxW-1:0] pick;
    logic            found;

    for (genvar i = 0; i < int'(R); i++) begin : gen_unpack
        assign wdata_arr[i] = wdata[i*N +: N];
    end

    // Scan from the farthest candidate back to ptr+1 so the nearest set request wins;
    // ptr itself (the previous owner) is the last candidate.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = ptr;
        for (int k = int'(R); k >= 1; k--) begin
            cand = IdxW'((int'(ptr) + k) % int'(R));
            if (req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

`ifdef REG_ARB_LOCK_EN
    localparam logic [7:0] LockMaxC = 8'(LOCK_MAX);

    logic [7:0] lock_cnt;
    logic       hold;

    assign hold = (state == StLock) && req[owner] && lock[owner] && (lock_cnt < LockMaxC);
`else
    logic unused_lock;

    assign unused_lock = ^{lock, state};
    assign locked      = 1'b0;
`endif

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            ptr     <= IdxW'(R - 1);
            gnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            owner   <= '0;
`ifdef REG_ARB_LOCK_EN
            locked   <= 1'b0;
            lock_cnt <= '0;
        end else if (hold) begin
            // Burst continues: owner and ptr already point at the holder.
            gnt        <= '0;
            gnt[owner] <= 1'b1;
            q          <= wdata_arr[owner];
            lock_cnt   <= lock_cnt + 8'd1;
`endif
        end else if (found) begin
            gnt       <= '0;
            gnt[pick] <= 1'b1;
            q         <= wdata_arr[pick];
            q_valid   <= 1'b1;
            ptr       <= pick;
            owner     <= pick;
`ifdef REG_ARB_LOCK_EN
            if (lock[pick]) begin
                state    <= StLock;
                locked   <= 1'b1;
                lock_cnt <= 8'd1;
            end else begin
                state    <= StServe;
                locked   <= 1'b0;
                lock_cnt <= '0;
            end
`else
            state <= StServe;
`endif
        end else begin
            gnt   <= '0;
            state <= StIdle;
`ifdef REG_ARB_LOCK_EN
            locked   <= 1'b0;
            lock_cnt <= '0;
`endif
        end
    end

    gnt_onehot_a: assert property (@(negedge clk) disable iff (reset) $onehot0(gnt));
    locked_gnt_a: assert property (@(negedge clk) disable iff (reset) locked |-> (gnt != '0));

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares one N-bit datapath register between R requesters. Each falling clock edge it picks at most one requester, loads that requester's data into the register, and reports the grant back. An optional lock lets one requester hold ownership for a bounded burst. It sits between the requesting datapath units and the register they share, and uses the same falling-edge capture as the datapath registers.

## Interface
- N, default 32: register and per-requester data width.
- R, default 4: number of requesters, legal range 2..8.
- LOCK_MAX, default 8: maximum number of consecutive locked grants to one owner, legal range 1..255.
- clk  input  1  clock; all state updates on the falling edge.
- reset  input  1  reset, asynchronous, active-high.
- req  input  R  per-requester write request, level-sensitive.
- lock  input  R  per-requester ownership-hold request; only meaningful together with req.
- wdata  input  R*N  packed write data; requester i occupies bits [i*N +: N].
- gnt  output  R  registered one-hot acknowledge; bit i high means wdata of requester i was captured at the last falling edge.
- q  output  N  shared register contents.
- q_valid  output  1  high once at least one write has occurred since reset.
- owner  output  clog2(R)  index of the last requester granted.
- locked  output  1  high while the state is LOCK.

## Operation
- States:
  - IDLE: no grant at the last edge.
  - SERVE: granted, not locked.
  - LOCK: the owner holds the lock.
- Pointer `ptr` is the last granted index. Round-robin search starts at ptr+1 and wraps modulo R.
- Actions at each falling edge, evaluated in order:
  1. LOCK, req[owner]=1, lock[owner]=1 and lock_cnt < LOCK_MAX: grant owner again and increment lock_cnt.
  2. Otherwise, if any req is set: grant the first set req at or after ptr+1.
     - The owner that just released or was forced out is searched last.
     - Set ptr and owner to the granted index. Load q with its wdata and set q_valid to 1.
     - Next state is LOCK with lock_cnt=1 if lock of the granted requester is 1, else SERVE.
  3. Otherwise: gnt=0, q holds, next state IDLE.
- Forced release: when lock_cnt reaches LOCK_MAX, the next edge re-arbitrates under rule 2. The owner may be re-granted only if no other req is set.
- A requester drops req after seeing its gnt bit. If req is still high, it is a new request.
- lock with req=0 is ignored.
- gnt is always one-hot or zero.
- owner, ptr and q change only on a grant.

## Timing
- Reset values:
  - gnt=0, q=0, q_valid=0, owner=0, locked=0.
  - state=IDLE, lock_cnt=0, ptr=R-1, so requester 0 is searched first.
- Latency: a req set up before a falling edge is serviced at that edge. q and gnt update at that edge and are visible for the following full cycle.
- Throughput: one write per cycle. Worst-case wait with all requesters active is (R-1)*LOCK_MAX cycles.
- Reset asserted at any time, including mid-lock, clears all state immediately. The first grant after reset release is at the first falling edge with reset low.
- A req and lock change at the same edge as a grant takes effect at the next edge.

## Configuration
- REG_ARB_LOCK_EN defined: LOCK state, lock_cnt and the locked output are active as described.
- Not defined:
  - The lock port is present but ignored.
  - The state machine uses only IDLE and SERVE.
  - locked is tied to 0.
  - The block is a pure round-robin arbiter.

## Test plan
All scenarios use N=32, R=4, LOCK_MAX=3, REG_ARB_LOCK_EN defined unless noted.
- Reset: assert reset with arbitrary inputs -> gnt=0000, q=0, q_valid=0, owner=0, locked=0; stays so until reset is released.
- Single request: req=0100, wdata[2]=0xDEADBEEF for one edge -> q=0xDEADBEEF, gnt=0100 for one cycle, owner=2, q_valid=1; next edge gives gnt=0000 and q held.
- Full contention: req=1111 held, wdata[i]=0x1000+i -> grants 0001,0010,0100,1000,0001 on consecutive edges; q follows 0x1000..0x1003,0x1000.
- Lock bound: req=1010, lock=0010 -> gnt=0010 on three edges with locked=1, then gnt=1000 with locked=0, then gnt=0010 again.
- Reset mid-lock: assert reset during the second locked grant -> all outputs zero at once; after release with req=1111 the first grant is 0001.
- Lock disabled: macro undefined, the lock-bound stimulus -> gnt alternates 0010,1000 every edge and locked stays 0.
